// File: rtl/serial_adder_n.sv
// Bit-serial adder/subtractor: one full-adder slice and a carry flop produce one
// result bit per clock, LSB first, behind a start/busy/done handshake.
module serial_adder_n #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sb_q, sr_q, sum_q;
  logic             c_q, cout_q, ovf_q;
  logic [CW-1:0]    i_q;
  logic             r, c_nxt, last;

  assign r     = sa_q[0] ^ sb_q[0] ^ c_q;
  assign c_nxt = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);
  assign last  = (i_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // On the last slice c_q is the carry into the MSB, so overflow needs no separate flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q   <= '0;
      sb_q   <= '0;
      sr_q   <= '0;
      sum_q  <= '0;
      c_q    <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      i_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            sa_q <= a;
            sb_q <= sub ? ~b : b;
            c_q  <= sub;
            i_q  <= '0;
          end
        end
        RUN: begin
          sa_q <= sa_q >> 1;
          sb_q <= sb_q >> 1;
          sr_q <= {r, sr_q[WIDTH-1:1]};
          c_q  <= c_nxt;
          i_q  <= i_q + 1'b1;
          if (last) begin
            sum_q  <= {r, sr_q[WIDTH-1:1]};
            cout_q <= c_nxt;
            ovf_q  <= c_q ^ c_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed and randomized checks of serial_adder_n at WIDTH=8 and an exhaustive WIDTH=2 sweep.
module tb_serial_adder_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       busy8, done8, cout8, ov8;

  logic       start2 = 1'b0, sub2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0, sum2;
  logic       busy2, done2, cout2, ov2;

  int checks = 0;
  int failures = 0;

  serial_adder_n #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ov8)
  );

  serial_adder_n #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .overflow(ov2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned modulo arithmetic for sum/carry, signed integer range test for overflow.
  task automatic ref_model(input int w, input longint ua, input longint ub, input bit s,
                           output longint rsum, output bit rc, output bit rov);
    longint m, full, sa, sb, res;
    m    = (longint'(1) << w) - 1;
    full = s ? (ua + ((~ub) & m) + 1) : (ua + ub);
    rsum = full & m;
    rc   = ((full >> w) & 1) != 0;
    sa   = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
    sb   = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
    res  = s ? sa - sb : sa + sb;
    rov  = (res < -(longint'(1) << (w - 1))) || (res > (longint'(1) << (w - 1)) - 1);
  endtask

  // One WIDTH=8 operation; disturb=1 pulses start with new operands and toggles sub mid-run.
  task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                     input logic ts, input bit disturb,
                     input logic [7:0] esum, input logic ecout, input logic eov);
    logic [7:0] prev, csum;
    logic       ccout, cov;
    int         donek, ndone, nbusy;
    bit         stable;
    @(negedge clk);
    a8 = ta; b8 = tb; sub8 = ts; start8 = 1'b1;
    @(posedge clk);
    prev = sum8; csum = 'x; ccout = 1'bx; cov = 1'bx;
    donek = -1; ndone = 0; nbusy = 0; stable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (disturb) begin
        sub8 = ~sub8;
        if (k == 2) begin start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; end
      end
      if (busy8) nbusy++;
      if (done8) begin
        ndone++;
        if (donek < 0) begin donek = k; csum = sum8; ccout = cout8; cov = ov8; end
      end
      if (k < 8 && sum8 !== prev) stable = 1'b0;
    end
    start8 = 1'b0;
    check({tag, ".done_edge"}, donek, 8);
    check({tag, ".done_count"}, ndone, 1);
    check({tag, ".busy_cycles"}, nbusy, 9);
    check({tag, ".no_partial"}, stable, 1);
    check({tag, ".sum"}, csum, esum);
    check({tag, ".cout"}, ccout, ecout);
    check({tag, ".overflow"}, cov, eov);
  endtask

  task automatic op2(input logic [1:0] ta, input logic [1:0] tb, input logic ts);
    longint rs;
    bit     rc, rv;
    bit     seen;
    ref_model(2, longint'(ta), longint'(tb), ts, rs, rc, rv);
    @(negedge clk);
    a2 = ta; b2 = tb; sub2 = ts; start2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      if (done2) seen = 1'b1;
      else @(negedge clk);
    end
    check($sformatf("w2.done a=%0d b=%0d s=%0d", ta, tb, ts), seen, 1);
    check($sformatf("w2.csum a=%0d b=%0d s=%0d", ta, tb, ts), {cout2, sum2}, {rc, rs[1:0]});
    check($sformatf("w2.ovf a=%0d b=%0d s=%0d", ta, tb, ts), ov2, rv);
    @(negedge clk);
  endtask

  initial begin
    longint     rs;
    bit         rc, rv;
    logic [7:0] ra, rb;
    logic       rsub;
    int         ndone, d1, d2;

    #12;
    check("rst.busy8", busy8, 0);
    check("rst.done8", done8, 0);
    check("rst.sum8", sum8, 0);
    check("rst.cout8", cout8, 0);
    check("rst.ov8", ov8, 0);
    check("rst.busy2", busy2, 0);
    @(negedge clk);
    rst_n = 1'b1;

    op8("add_35_4a", 8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0);
    op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("sub_10_20", 8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0);
    op8("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
    op8("sub_05_05", 8'h05, 8'h05, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("disturb", 8'h01, 8'h01, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0);

    // start held high: re-accepted on the first IDLE edge after DONE
    @(negedge clk);
    a8 = 8'h21; b8 = 8'h12; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    ndone = 0; d1 = -1; d2 = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 19) start8 = 1'b0;
      if (done8) begin
        ndone++;
        if (d1 < 0) d1 = k; else d2 = k;
      end
    end
    check("hold.count", ndone, 2);
    check("hold.first", d1, 8);
    check("hold.second", d2, 18);
    check("hold.sum", sum8, 8'h33);
    repeat (3) @(negedge clk);

    // asynchronous reset mid-run
    a8 = 8'h33; b8 = 8'h44; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst.busy", busy8, 0);
    check("arst.done", done8, 0);
    check("arst.sum", sum8, 0);
    check("arst.cout", cout8, 0);
    check("arst.ov", ov8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    op8("after_rst", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rsub = 1'($urandom_range(0, 1));
      ref_model(8, longint'(ra), longint'(rb), rsub, rs, rc, rv);
      op8($sformatf("rnd%0d", n), ra, rb, rsub, 1'b0, rs[7:0], rc, rv);
    end

    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 4; x++)
        for (int y = 0; y < 4; y++)
          op2(2'(x), 2'(y), 1'(s));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
